// File: rtl/alu_seq_pkg.sv
// alu_seq shared definitions: opcodes, FSM states, op classification.
// Optional divider selected by ALU_SEQ_DIV_EN.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SGTU  = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_RSUB  = 4'd9;
  localparam logic [3:0] OP_PASS  = 4'd10;
  localparam logic [3:0] OP_CMOVZ = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_RSVD  = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq iterative datapath: shift-add multiply, optional restoring divide.
// Divide hardware exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             hi_nonzero,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  logic [WIDTH-1:0] hi, lo, opd;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    cnt;
  logic             run;

`ifdef ALU_SEQ_DIV_EN
  logic md;
  logic ge;
  logic [WIDTH:0] shl;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // one multiply or divide step from the current partial state
  always_comb begin
    sum   = '0;
    hi_nx = hi;
    lo_nx = lo;
`ifdef ALU_SEQ_DIV_EN
    ge  = 1'b0;
    shl = {hi, lo[M]};
    if (md) begin
      ge    = shl >= {1'b0, opd};
      sum   = ge ? shl - {1'b0, opd} : shl;
      hi_nx = sum[M:0];
      lo_nx = {lo[M-1:0], ge};
    end else begin
`endif
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[M:1]};
`ifdef ALU_SEQ_DIV_EN
    end
`endif
  end

  // load operands on start, then advance one step per cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
      opd <= '0;
`ifdef ALU_SEQ_DIV_EN
      md  <= 1'b0;
`endif
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(WIDTH - 1);
      hi  <= '0;
`ifdef ALU_SEQ_DIV_EN
      md  <= mode;
      lo  <= mode ? a : b;
      opd <= mode ? b : a;
`else
      lo  <= b;
      opd <= a;
`endif
    end else if (run) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
      cnt <= cnt - 1'b1;
      if (cnt == '0) run <= 1'b0;
    end
  end

  assign done       = run && (cnt == '0);
  assign quo        = lo_nx;
  assign rem        = hi_nx;
  assign hi_nonzero = |hi_nx;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, 1-cycle ops plus iterative MUL.
// Define ALU_SEQ_DIV_EN to add iterative DIV/REM.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   codop,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             neg,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);

  localparam int M = WIDTH - 1;

  state_t           state, state_nx;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   sh;
  logic             acc, iter_op, it_start, mode;
  logic             it_done, it_hinz, it_ov;
  logic [WIDTH-1:0] it_quo, it_rem, it_res;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH:0]   ext;
  logic             ov_c, cy_c, z_c, rsvd_c;

  assign op        = codop[3:0];
  assign a         = operando1;
  assign b         = operando2;
  assign sh        = b[SHW-1:0];
  assign iter_op   = is_iterative(op);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);
  assign in_ready  = (state != S_BUSY) && (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign it_start  = acc && iter_op;
  assign mode      = (op != OP_MUL);

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (it_start),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .quo        (it_quo),
    .rem        (it_rem),
    .hi_nonzero (it_hinz),
    .done       (it_done)
  );

`ifdef ALU_SEQ_DIV_EN
  logic [3:0] op_q;
  logic       bz_q;

  // remember which iterative op is running and whether B was zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_MUL;
      bz_q <= 1'b0;
    end else if (it_start) begin
      op_q <= op;
      bz_q <= (b == '0);
    end
  end

  // select iterative result and overflow per op
  always_comb begin
    it_res = it_quo;
    it_ov  = it_hinz;
    if (op_q == OP_REM) it_res = it_rem;
    if (op_q != OP_MUL) it_ov = bz_q;
  end
`else
  logic [WIDTH-1:0] unused_rem;
  assign unused_rem = it_rem;
  assign it_res     = it_quo;
  assign it_ov      = it_hinz;
`endif

  // single-cycle result and flags
  always_comb begin
    r_c    = '0;
    ext    = '0;
    ov_c   = 1'b0;
    cy_c   = 1'b0;
    rsvd_c = 1'b0;
    unique case (1'b1)
      op == OP_ADD: begin
        ext  = {1'b0, a} + {1'b0, b};
        r_c  = ext[M:0];
        cy_c = ext[WIDTH];
        ov_c = (~a[M] & ~b[M] & r_c[M]) | (a[M] & b[M] & ~r_c[M]);
      end
      op == OP_SUB: begin
        ext  = {1'b0, a} - {1'b0, b};
        r_c  = ext[M:0];
        cy_c = ext[WIDTH];
        ov_c = (a[M] & ~b[M] & ~r_c[M]) | (~a[M] & b[M] & r_c[M]);
      end
      op == OP_RSUB: begin
        ext  = {1'b0, b} - {1'b0, a};
        r_c  = ext[M:0];
        cy_c = ext[WIDTH];
        ov_c = (b[M] & ~a[M] & ~r_c[M]) | (~b[M] & a[M] & r_c[M]);
      end
      op == OP_SGTU:  r_c = {{M{1'b0}}, a > b};
      op == OP_AND:   r_c = a & b;
      op == OP_OR:    r_c = a | b;
      op == OP_XOR:   r_c = a ^ b;
      op == OP_SLL:   r_c = a << sh;
      op == OP_SRL:   r_c = a >> sh;
      op == OP_SRA:   r_c = $unsigned($signed(a) >>> sh);
      op == OP_PASS:  r_c = a;
      op == OP_CMOVZ: r_c = (a == '0) ? b : a;
      default:        rsvd_c = 1'b1;
    endcase
    if (op == OP_CMOVZ) z_c = (a == '0);
    else                z_c = !rsvd_c && (r_c == '0);
  end

  // control state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state: accept, iterate, hold until consumed
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (acc)
          state_nx = iter_op ? S_BUSY : S_DONE;
        else if (state == S_DONE && out_ready)
          state_nx = S_IDLE;
      end
      S_BUSY:  if (it_done) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // result and flags registered together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resultado <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
    end else if (acc && !iter_op) begin
      resultado <= r_c;
      neg       <= r_c[M];
      zero      <= z_c;
      overflow  <= ov_c;
      carry     <= cy_c;
    end else if (busy && it_done) begin
      resultado <= it_res;
      neg       <= it_res[M];
      zero      <= (it_res == '0);
      overflow  <= it_ov;
      carry     <= 1'b0;
    end
  end

endmodule
